// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the windowed SPARC integer register file.
package regfile_pkg;

    // Physical register count for a given window count: 8 globals + 16 per window.
    function automatic int unsigned phys_regs(input int unsigned nwin);
        return 8 + 16 * nwin;
    endfunction

    localparam int unsigned NWINDOWS_DEF = 8;
    localparam int unsigned WIDTH_DEF    = 32;
    localparam int unsigned PHYS_REGS    = phys_regs(NWINDOWS_DEF);
    localparam int unsigned WIN_W        = $clog2(NWINDOWS_DEF);
    localparam int unsigned ADDR_W       = 5;

    // Physical layout: globals first, then 16 registers (outs, locals) per window.
    localparam int unsigned NUM_GLOBALS  = 8;
    localparam int unsigned WIN_STRIDE   = 16;
    localparam int unsigned LOCALS_OFS   = 8;

    // Logical register group bases.
    localparam logic [4:0] R0_ADDR     = 5'd0;
    localparam logic [4:0] OUTS_BASE   = 5'd8;
    localparam logic [4:0] LOCALS_BASE = 5'd16;
    localparam logic [4:0] INS_BASE    = 5'd24;

endpackage

// File: rtl/windowed_register_file_if.sv
// Register file access bus: read ports, write port and window control.
interface windowed_register_file_if #(
    parameter int unsigned NWINDOWS = 8,
    parameter int unsigned WIDTH    = 32
);
    logic [4:0]          ra_a;
    logic [4:0]          ra_b;
    logic [WIDTH-1:0]    rd_a;
    logic [WIDTH-1:0]    rd_b;
    logic                we;
    logic [4:0]          wa;
    logic [WIDTH-1:0]    wd;
    logic                save;
    logic                restore;
    logic                cwp_we;
    logic [4:0]          cwp_wdata;
    logic                wim_we;
    logic [NWINDOWS-1:0] wim_wdata;
    logic [4:0]          cwp;
    logic [NWINDOWS-1:0] wim;
    logic                win_ovf;
    logic                win_unf;

    modport master (
        output ra_a, ra_b, we, wa, wd, save, restore, cwp_we, cwp_wdata, wim_we, wim_wdata,
        input  rd_a, rd_b, cwp, wim, win_ovf, win_unf
    );

    modport slave (
        input  ra_a, ra_b, we, wa, wd, save, restore, cwp_we, cwp_wdata, wim_we, wim_wdata,
        output rd_a, rd_b, cwp, wim, win_ovf, win_unf
    );
endinterface

// File: rtl/window_addr_map.sv
// Maps a logical register (r0..r31) in a given window to its physical index.
module window_addr_map
    import regfile_pkg::*;
#(
    parameter int unsigned NWINDOWS = NWINDOWS_DEF
) (
    input  logic [4:0]                              addr_i,
    input  logic [$clog2(NWINDOWS)-1:0]             win_i,
    output logic [$clog2(phys_regs(NWINDOWS))-1:0]  phys_o
);
    localparam int unsigned PhysW = $clog2(phys_regs(NWINDOWS));

    int unsigned win_next;
    int unsigned idx;

    // Ins resolve to the outs of the next window up, wrapping at NWINDOWS.
    always_comb begin
        win_next = (32'(win_i) == NWINDOWS - 1) ? 0 : 32'(win_i) + 1;
        if (addr_i < OUTS_BASE) begin
            idx = 32'(addr_i);
        end else if (addr_i < LOCALS_BASE) begin
            idx = NUM_GLOBALS + WIN_STRIDE * 32'(win_i) + 32'(addr_i - OUTS_BASE);
        end else if (addr_i < INS_BASE) begin
            idx = NUM_GLOBALS + WIN_STRIDE * 32'(win_i) + LOCALS_OFS
                + 32'(addr_i - LOCALS_BASE);
        end else begin
            idx = NUM_GLOBALS + WIN_STRIDE * win_next + 32'(addr_i - INS_BASE);
        end
        phys_o = idx[PhysW-1:0];
    end
endmodule

// File: rtl/windowed_register_file.sv
// SPARC V8 windowed integer register file with CWP/WIM and SAVE/RESTORE handling.
module windowed_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned NWINDOWS = NWINDOWS_DEF,
    parameter int unsigned WIDTH    = WIDTH_DEF
) (
    input logic                      clk,
    input logic                      reset_n,
    windowed_register_file_if.slave  bus
);
    localparam int unsigned PhysRegs = phys_regs(NWINDOWS);
    localparam int unsigned PhysW    = $clog2(PhysRegs);
    localparam int unsigned WinW     = $clog2(NWINDOWS);
    localparam logic [WinW-1:0] WinMax = WinW'(NWINDOWS - 1);

    logic [WinW-1:0]     cwp_q, cwp_d;
    logic [NWINDOWS-1:0] wim_q, wim_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [WIDTH-1:0]    regs_q [PhysRegs];
    logic [WIDTH-1:0]    regs_d [PhysRegs];

    logic [WinW-1:0]  nw_save, nw_rest, wwin;
    logic             save_req, restore_req, save_ok, restore_ok, wr_en;
    logic [PhysW-1:0] phys_a, phys_b, phys_w;

    window_addr_map #(.NWINDOWS(NWINDOWS)) u_map_a (
        .addr_i (bus.ra_a),
        .win_i  (cwp_q),
        .phys_o (phys_a)
    );

    window_addr_map #(.NWINDOWS(NWINDOWS)) u_map_b (
        .addr_i (bus.ra_b),
        .win_i  (cwp_q),
        .phys_o (phys_b)
    );

    window_addr_map #(.NWINDOWS(NWINDOWS)) u_map_w (
        .addr_i (bus.wa),
        .win_i  (wwin),
        .phys_o (phys_w)
    );

    // Window control: cwp_we overrides, simultaneous save+restore is a no-op,
    // and the WIM check always uses the pre-edge mask.
    always_comb begin
        nw_save     = (cwp_q == '0) ? WinMax : cwp_q - WinW'(1);
        nw_rest     = (cwp_q == WinMax) ? '0 : cwp_q + WinW'(1);
        save_req    = bus.save & ~bus.restore & ~bus.cwp_we;
        restore_req = bus.restore & ~bus.save & ~bus.cwp_we;
        save_ok     = save_req & ~wim_q[nw_save];
        restore_ok  = restore_req & ~wim_q[nw_rest];
        ovf_d       = save_req & wim_q[nw_save];
        unf_d       = restore_req & wim_q[nw_rest];

        cwp_d = cwp_q;
        if (bus.cwp_we) begin
            cwp_d = WinW'(bus.cwp_wdata);
        end else if (save_ok) begin
            cwp_d = nw_save;
        end else if (restore_ok) begin
            cwp_d = nw_rest;
        end

        // A successful SAVE/RESTORE writes its rd into the new window.
        wwin = save_ok ? nw_save : (restore_ok ? nw_rest : cwp_q);

        wim_d = bus.wim_we ? bus.wim_wdata : wim_q;
    end

    // Register array next state; writes to r0 are dropped.
    always_comb begin
        wr_en  = bus.we && (bus.wa != R0_ADDR);
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[phys_w] = bus.wd;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cwp_q <= '0;
            wim_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < PhysRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            cwp_q  <= cwp_d;
            wim_q  <= wim_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            regs_q <= regs_d;
        end
    end

    // Combinational reads against the current window; no write bypass.
    always_comb begin
        bus.rd_a    = (bus.ra_a == R0_ADDR) ? '0 : regs_q[phys_a];
        bus.rd_b    = (bus.ra_b == R0_ADDR) ? '0 : regs_q[phys_b];
        bus.cwp     = 5'(cwp_q);
        bus.wim     = wim_q;
        bus.win_ovf = ovf_q;
        bus.win_unf = unf_q;
    end
endmodule
